mux_scan_sequencer: RTL and testbench

Sequencer directly upstream of the 4:1 mux stage: drives the mux's 2-bit select through the enabled channels and samples the 1-bit mux output once per channel. It assembles the samples into a 4-bit frame with a one-cycle valid pulse. Dwell and settle time per channel are programmable, so the mux inputs can be scanned slowly (debounced switches) or back-to-back.

---
 rtl/mux_scan_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - 4:1 mux scan sequencer with programmable settle/dwell and frame assembly
module mux_scan_sequencer #(
  parameter int SETTLE  = 1,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y_in,
  output logic [1:0]         sel,
  output logic               busy,
  output logic [3:0]         frame,
  output logic               frame_valid,
  output logic               err
);

  // One counter serves both the settle and the dwell phase, so it must hold
  // whichever range is larger (settle is at most 15).
  localparam int CW = (DWELL_W > 4) ? DWELL_W : 4;
  localparam logic [CW-1:0] SETTLE_LAST = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
  localparam logic          NO_SETTLE   = (SETTLE == 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DWELL  = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [CW-1:0] dwell_q, dwell_n;
  logic [1:0]    ch_q, ch_n;
  logic [3:0]    mask_q, mask_n;
  logic [3:0]    buf_q, buf_n;
  logic [3:0]    buf_sampled;
  logic [1:0]    sel_n;
  logic          busy_n;
  logic [3:0]    frame_n;
  logic          fv_n;
  logic          err_n;
  logic          has_next;
  logic [1:0]    next_ch;
  logic [1:0]    first_ch_in;
  logic [1:0]    first_ch_q;
  logic [CW-1:0] dwell_in;

  // Index of the lowest enabled channel; callers guarantee m is non-zero.
  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Index of the nearest enabled channel strictly above c.
  function automatic logic [1:0] next_above(input logic [3:0] m, input logic [1:0] c);
    logic [1:0] r;
    r = c;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(c))) r = 2'(i);
    end
    return r;
  endfunction

  // True when some enabled channel lies above c, i.e. the scan is not over.
  function automatic logic any_above(input logic [3:0] m, input logic [1:0] c);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m[i] && (i > int'(c))) r = 1'b1;
    end
    return r;
  endfunction

  // Channel-walk helpers and the buffer with the current sample merged in.
  always_comb begin
    has_next       = any_above(mask_q, ch_q);
    next_ch        = next_above(mask_q, ch_q);
    first_ch_in    = lowest_bit(mask);
    first_ch_q     = lowest_bit(mask_q);
    dwell_in       = (dwell == '0) ? CW'(1) : CW'(dwell);
    buf_sampled    = buf_q;
    buf_sampled[ch_q] = y_in;
  end

  // Next-state and registered-output logic for the scan FSM.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    dwell_n = dwell_q;
    ch_n    = ch_q;
    mask_n  = mask_q;
    buf_n   = buf_q;
    sel_n   = sel;
    busy_n  = busy;
    frame_n = frame;
    fv_n    = 1'b0;
    err_n   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mask != 4'b0000) begin
            mask_n  = mask;
            dwell_n = dwell_in;
            buf_n   = 4'b0000;
            ch_n    = first_ch_in;
            sel_n   = first_ch_in;
            busy_n  = 1'b1;
            cnt_n   = '0;
            state_n = NO_SETTLE ? S_DWELL : S_SETTLE;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_n   = '0;
          state_n = S_DWELL;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end

      S_DWELL: begin
        if (cnt_q == (dwell_q - CW'(1))) begin
          cnt_n = '0;
          buf_n = buf_sampled;
          if (has_next) begin
            ch_n    = next_ch;
            sel_n   = next_ch;
            state_n = NO_SETTLE ? S_DWELL : S_SETTLE;
          end else begin
            frame_n = buf_sampled;
            fv_n    = 1'b1;
            if (cont) begin
              // Back-to-back restart: the first channel of the next scan
              // begins while frame_valid is high, with no idle gap.
              buf_n   = 4'b0000;
              ch_n    = first_ch_q;
              sel_n   = first_ch_q;
              state_n = NO_SETTLE ? S_DWELL : S_SETTLE;
            end else begin
              ch_n    = 2'd0;
              sel_n   = 2'd0;
              busy_n  = 1'b0;
              state_n = S_IDLE;
            end
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any scan and clears the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dwell_q     <= '0;
      ch_q        <= 2'd0;
      mask_q      <= 4'b0000;
      buf_q       <= 4'b0000;
      sel         <= 2'd0;
      busy        <= 1'b0;
      frame       <= 4'b0000;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      dwell_q     <= dwell_n;
      ch_q        <= ch_n;
      mask_q      <= mask_n;
      buf_q       <= buf_n;
      sel         <= sel_n;
      busy        <= busy_n;
      frame       <= frame_n;
      frame_valid <= fv_n;
      err         <= err_n;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - directed self-checking bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic [3:0] mask;
  logic [7:0] dwell;
  logic       y_in;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] frame;
  logic       frame_valid;
  logic       err;

  // Mux model: bit i is the level on mux input i (a=0 .. d=3).
  logic [3:0] muxin;
  assign y_in = muxin[sel];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  mux_scan_sequencer #(.SETTLE(1), .DWELL_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cont        (cont),
    .mask        (mask),
    .dwell       (dwell),
    .y_in        (y_in),
    .sel         (sel),
    .busy        (busy),
    .frame       (frame),
    .frame_valid (frame_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Drives start for one edge (edge 0) and returns at the negedge after it.
  // mask/dwell are then scrambled to show they were latched.
  task automatic begin_scan(input logic [3:0] m, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1;
    mask  = m;
    dwell = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mask  = 4'b0000;
    dwell = 8'd7;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    mask  = 4'b0000;
    dwell = 8'd0;
    muxin = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (sel !== 2'd0) $display("FAIL reset_sel got %0d exp 0", sel); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (frame !== 4'b0000) $display("FAIL reset_frame got %b exp 0000", frame); else pass_cnt++;
    chk_cnt++; if (frame_valid !== 1'b0) $display("FAIL reset_fv got %b exp 0", frame_valid); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_full_scan();
    logic [1:0] es;
    muxin = 4'b1101;
    begin_scan(4'b1111, 8'd2);
    for (int e = 0; e <= 13; e++) begin
      es = (e < 12) ? 2'(e / 3) : 2'd0;
      chk_cnt++; if (sel !== es) $display("FAIL full_sel e=%0d got %0d exp %0d", e, sel, es); else pass_cnt++;
      chk_cnt++; if (busy !== (e < 12)) $display("FAIL full_busy e=%0d got %b exp %b", e, busy, (e < 12)); else pass_cnt++;
      chk_cnt++; if (frame_valid !== (e == 12)) $display("FAIL full_fv e=%0d got %b exp %b", e, frame_valid, (e == 12)); else pass_cnt++;
      chk_cnt++;
      if (frame !== ((e >= 12) ? 4'b1101 : 4'b0000)) $display("FAIL full_frame e=%0d got %b exp %b", e, frame, ((e >= 12) ? 4'b1101 : 4'b0000));
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_sparse();
    logic [1:0] es;
    muxin = 4'b0111;
    begin_scan(4'b1010, 8'd0);
    for (int e = 0; e <= 5; e++) begin
      es = (e < 2) ? 2'd1 : ((e < 4) ? 2'd3 : 2'd0);
      chk_cnt++; if (sel !== es) $display("FAIL sparse_sel e=%0d got %0d exp %0d", e, sel, es); else pass_cnt++;
      chk_cnt++; if (busy !== (e < 4)) $display("FAIL sparse_busy e=%0d got %b exp %b", e, busy, (e < 4)); else pass_cnt++;
      chk_cnt++; if (frame_valid !== (e == 4)) $display("FAIL sparse_fv e=%0d got %b exp %b", e, frame_valid, (e == 4)); else pass_cnt++;
      chk_cnt++;
      if (frame !== ((e >= 4) ? 4'b0010 : 4'b1101)) $display("FAIL sparse_frame e=%0d got %b exp %b", e, frame, ((e >= 4) ? 4'b0010 : 4'b1101));
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_dwell_timing();
    muxin = 4'b0000;
    begin_scan(4'b0100, 8'd4);
    for (int e = 0; e <= 6; e++) begin
      chk_cnt++; if (sel !== ((e < 5) ? 2'd2 : 2'd0)) $display("FAIL dwell_sel e=%0d got %0d", e, sel); else pass_cnt++;
      chk_cnt++; if (busy !== (e < 5)) $display("FAIL dwell_busy e=%0d got %b exp %b", e, busy, (e < 5)); else pass_cnt++;
      chk_cnt++; if (frame_valid !== (e == 5)) $display("FAIL dwell_fv e=%0d got %b exp %b", e, frame_valid, (e == 5)); else pass_cnt++;
      if (e == 5) begin
        chk_cnt++; if (frame !== 4'b0100) $display("FAIL dwell_frame got %b exp 0100", frame); else pass_cnt++;
      end
      if (e == 1) muxin[2] = 1'b1;
      if (e == 2) muxin[2] = 1'b0;
      if (e == 3) muxin[2] = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_continuous();
    logic [1:0] es;
    logic       efv;
    logic [3:0] ef;
    cont  = 1'b1;
    muxin = 4'b0010;
    begin_scan(4'b0011, 8'd2);
    for (int e = 0; e <= 30; e++) begin
      es  = (e < 24) ? (((e % 6) < 3) ? 2'd0 : 2'd1) : 2'd0;
      efv = (e == 6) || (e == 12) || (e == 18) || (e == 24);
      ef  = (e < 18) ? 4'b0010 : 4'b0001;
      chk_cnt++; if (sel !== es) $display("FAIL cont_sel e=%0d got %0d exp %0d", e, sel, es); else pass_cnt++;
      chk_cnt++; if (busy !== (e < 24)) $display("FAIL cont_busy e=%0d got %b exp %b", e, busy, (e < 24)); else pass_cnt++;
      chk_cnt++; if (frame_valid !== efv) $display("FAIL cont_fv e=%0d got %b exp %b", e, frame_valid, efv); else pass_cnt++;
      if (efv) begin
        chk_cnt++; if (frame !== ef) $display("FAIL cont_frame e=%0d got %b exp %b", e, frame, ef); else pass_cnt++;
      end
      if (e == 12) muxin = 4'b0001;
      if (e == 20) cont = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_error_ignore();
    @(negedge clk);
    start = 1'b1;
    mask  = 4'b0000;
    dwell = 8'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk_cnt++; if (err !== 1'b1) $display("FAIL err_pulse got %b exp 1", err); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL err_busy got %b exp 0", busy); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (err !== 1'b0) $display("FAIL err_clear got %b exp 0", err); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL err_busy2 got %b exp 0", busy); else pass_cnt++;

    muxin = 4'b1010;
    begin_scan(4'b1111, 8'd2);
    for (int e = 0; e <= 13; e++) begin
      chk_cnt++; if (sel !== ((e < 12) ? 2'(e / 3) : 2'd0)) $display("FAIL ign_sel e=%0d got %0d", e, sel); else pass_cnt++;
      chk_cnt++; if (frame_valid !== (e == 12)) $display("FAIL ign_fv e=%0d got %b exp %b", e, frame_valid, (e == 12)); else pass_cnt++;
      chk_cnt++; if (err !== 1'b0) $display("FAIL ign_err e=%0d got %b exp 0", e, err); else pass_cnt++;
      if (e == 12) begin
        chk_cnt++; if (frame !== 4'b1010) $display("FAIL ign_frame got %b exp 1010", frame); else pass_cnt++;
      end
      if (e == 5) begin
        start = 1'b1;
        mask  = 4'b0001;
        dwell = 8'd0;
      end
      if (e == 6) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_scan();
    muxin = 4'b1111;
    begin_scan(4'b1111, 8'd2);
    for (int e = 0; e <= 7; e++) begin
      chk_cnt++; if (sel !== 2'(e / 3)) $display("FAIL rmid_sel e=%0d got %0d exp %0d", e, sel, e / 3); else pass_cnt++;
      if (e < 7) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++; if (sel !== 2'd0) $display("FAIL rmid_sel0 got %0d exp 0", sel); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (frame !== 4'b0000) $display("FAIL rmid_frame got %b exp 0000", frame); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      chk_cnt++; if (frame_valid !== 1'b0) $display("FAIL rmid_nofv i=%0d got %b exp 0", i, frame_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rmid_idle i=%0d got %b exp 0", i, busy); else pass_cnt++;
      @(negedge clk);
    end

    muxin = 4'b0110;
    begin_scan(4'b1111, 8'd2);
    for (int e = 0; e <= 12; e++) begin
      chk_cnt++; if (sel !== ((e < 12) ? 2'(e / 3) : 2'd0)) $display("FAIL rnew_sel e=%0d got %0d", e, sel); else pass_cnt++;
      chk_cnt++; if (busy !== (e < 12)) $display("FAIL rnew_busy e=%0d got %b exp %b", e, busy, (e < 12)); else pass_cnt++;
      chk_cnt++; if (frame_valid !== (e == 12)) $display("FAIL rnew_fv e=%0d got %b exp %b", e, frame_valid, (e == 12)); else pass_cnt++;
      if (e == 12) begin
        chk_cnt++; if (frame !== 4'b0110) $display("FAIL rnew_frame got %b exp 0110", frame); else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse();
    test_dwell_timing();
    test_continuous();
    test_error_ignore();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
